avr_dbus_responder: RTL and testbench

- Responder end of the CPU data-memory interface (address / wb / w out, data in).
- Decodes every CPU data-space access.
  - I/O window 0x0020–0x005F is served by internal registers: UART transmitter with TX FIFO, output port, synchronised input pin bank.
  - All other addresses pass through to the synchronous SRAM.
- Returns read data with the same one-cycle latency as the SRAM, so the CPU sees one uniform data bus.

---
 rtl/avr_dbus_responder.sv | 201 ++++++++++++++++++++
 tb/tb_avr_dbus_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_dbus_responder.sv
// Data-bus responder: serves the 0x20-0x5F I/O window from internal registers
// (UART transmitter with TX FIFO, PORTB, PINB) and forwards every other access to SRAM.
module avr_dbus_responder #(
    parameter int unsigned CLK_DIV = 217,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  wb,
    input  logic        w,
    output logic [7:0]  data,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_wd,
    output logic        sram_we,
    input  logic [7:0]  sram_q,
    output logic [7:0]  port_out,
    input  logic [7:0]  pin_in,
    output logic        uart_tx,
    output logic        irq_udre
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef logic [FIFO_AW-1:0] ptr_t;
    typedef logic [FIFO_AW:0]   cnt_t;

    localparam cnt_t        DEPTH_C     = cnt_t'(DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [15:0] A_UCR       = 16'h002A;
    localparam logic [15:0] A_USR       = 16'h002B;
    localparam logic [15:0] A_UDR       = 16'h002C;
    localparam logic [15:0] A_PINB      = 16'h0036;
    localparam logic [15:0] A_PORTB     = 16'h0038;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    tx_state_t   state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic [7:0]  fifo_mem_q [DEPTH];
    ptr_t        wr_ptr_q;
    ptr_t        rd_ptr_q;
    cnt_t        count_q;
    cnt_t        count_d;
    logic        ovf_q;
    logic        txc_q;
    logic        udrie_q;
    logic [7:0]  port_q;
    logic [7:0]  pin_s1_q;
    logic [7:0]  pin_s2_q;
    logic        io_sel_q;
    logic [7:0]  io_q;
    logic [7:0]  io_d;

    logic in_win_s, wr_io_s, udre_s, fifo_ne_s, baud_end_s;
    logic pop_s, push_req_s, push_s, txc_set_s;

    assign in_win_s   = (address >= 16'h0020) && (address <= 16'h005F);
    assign wr_io_s    = w && in_win_s;
    assign udre_s     = count_q < DEPTH_C;
    assign fifo_ne_s  = count_q != cnt_t'(0);
    assign baud_end_s = baud_q == 16'd0;
    // A STOP-end pop frees a slot before the same-cycle push is judged.
    assign pop_s      = fifo_ne_s && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && baud_end_s));
    assign push_req_s = wr_io_s && (address == A_UDR);
    assign push_s     = push_req_s && (udre_s || pop_s);
    assign txc_set_s  = (state_q == ST_STOP) && baud_end_s && !fifo_ne_s;

    assign sram_addr = address;
    assign sram_wd   = wb;
    assign sram_we   = w && !in_win_s;
    assign data      = io_sel_q ? io_q : sram_q;
    assign port_out  = port_q;
    assign uart_tx   = tx_q;
    assign irq_udre  = udre_s && udrie_q;

    // I/O read decode and FIFO occupancy update.
    always_comb begin
        io_d    = 8'h00;
        count_d = count_q;
        case (address)
            A_USR:   io_d = {1'b0, txc_q, udre_s, 4'b0000, ovf_q};
            A_UCR:   io_d = {2'b00, udrie_q, 5'b00000};
            A_PORTB: io_d = port_q;
            A_PINB:  io_d = pin_s2_q;
            default: io_d = 8'h00;
        endcase
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase
    end

    // All state: bus registers, FIFO, status flags and the TX frame FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= 16'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            wr_ptr_q  <= ptr_t'(0);
            rd_ptr_q  <= ptr_t'(0);
            count_q   <= cnt_t'(0);
            ovf_q     <= 1'b0;
            txc_q     <= 1'b0;
            udrie_q   <= 1'b0;
            port_q    <= 8'h00;
            pin_s1_q  <= 8'h00;
            pin_s2_q  <= 8'h00;
            // io_sel resets high so data reads 0x00 regardless of sram_q.
            io_sel_q  <= 1'b1;
            io_q      <= 8'h00;
        end else begin
            pin_s1_q <= pin_in;
            pin_s2_q <= pin_s1_q;
            io_sel_q <= in_win_s;
            io_q     <= in_win_s ? io_d : 8'h00;
            count_q  <= count_d;

            if (wr_io_s && (address == A_PORTB)) port_q <= wb;
            if (wr_io_s && (address == A_UCR))   udrie_q <= wb[5];

            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= wb;
                wr_ptr_q             <= wr_ptr_q + ptr_t'(1);
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + ptr_t'(1);

            if (push_req_s && !push_s)                      ovf_q <= 1'b1;
            else if (wr_io_s && (address == A_USR) && wb[0]) ovf_q <= 1'b0;

            if (txc_set_s)                                  txc_q <= 1'b1;
            else if (wr_io_s && (address == A_USR) && wb[6]) txc_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop_s) begin
                        shift_q <= fifo_mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                        baud_q  <= BAUD_RELOAD;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        baud_q    <= BAUD_RELOAD;
                        bit_cnt_q <= 3'd0;
                        state_q   <= ST_DATA;
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_q <= BAUD_RELOAD;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_end_s) begin
                        if (pop_s) begin
                            shift_q <= fifo_mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                            baud_q  <= BAUD_RELOAD;
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q - 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_avr_dbus_responder.sv
// Scoreboard bench for avr_dbus_responder: read expectations are queued at issue time
// and checked by a separate monitor; a serial monitor decodes frames off uart_tx.
module tb_avr_dbus_responder;
    localparam int C       = 4;
    localparam int FRAME   = 10 * C;
    localparam int STOP_K  = 9 * C + C / 2;
    localparam logic [15:0] A_UCR = 16'h002A, A_USR = 16'h002B, A_UDR = 16'h002C;
    localparam logic [15:0] A_PINB = 16'h0036, A_PORTB = 16'h0038;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [7:0]  wb = 8'h00;
    logic        w = 1'b0;
    logic [7:0]  data;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wd;
    logic        sram_we;
    logic [7:0]  sram_q;
    logic [7:0]  port_out;
    logic [7:0]  pin_in = 8'h00;
    logic        uart_tx;
    logic        irq_udre;

    avr_dbus_responder #(.CLK_DIV(C), .FIFO_AW(2)) dut (
        .clock(clock), .reset(reset), .address(address), .wb(wb), .w(w), .data(data),
        .sram_addr(sram_addr), .sram_wd(sram_wd), .sram_we(sram_we), .sram_q(sram_q),
        .port_out(port_out), .pin_in(pin_in), .uart_tx(uart_tx), .irq_udre(irq_udre)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    always @(posedge clock) cyc_n <= cyc_n + 1;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
        end
    endfunction

    // Synchronous SRAM model, read-first, one-cycle latency.
    logic [7:0] smem [0:1023];
    always @(posedge clock) begin
        if (sram_we) smem[sram_addr[9:0]] <= sram_wd;
        sram_q <= smem[sram_addr[9:0]];
    end

    // Read scoreboard.
    string      sb_name[$];
    logic [7:0] sb_exp[$];
    logic       rd_req = 1'b0;
    logic       rd_issued_q = 1'b0;
    string      mon_nm;
    logic [7:0] mon_exp;
    always @(posedge clock) rd_issued_q <= rd_req;
    always @(negedge clock) begin
        if (rd_issued_q) begin
            if (sb_exp.size() == 0) begin
                check("unexpected_read", 32'(data), 32'hFFFF_FFFF);
            end else begin
                mon_nm  = sb_name.pop_front();
                mon_exp = sb_exp.pop_front();
                check(mon_nm, 32'(data), 32'(mon_exp));
            end
        end
    end

    // Serial line monitor: samples mid-bit, drops frames cut by reset.
    logic [7:0] rx_data[$];
    int         rx_t[$];
    logic [7:0] rx_byte;
    logic       rx_ok;
    int         rx_t0;
    always begin
        @(negedge clock);
        if (!reset && uart_tx === 1'b0) begin
            rx_t0   = cyc_n;
            rx_ok   = 1'b1;
            rx_byte = 8'h00;
            for (int k = 1; k <= STOP_K; k++) begin
                @(negedge clock);
                if (reset) rx_ok = 1'b0;
                if (k >= C + C / 2 && k < STOP_K && ((k - C / 2) % C) == 0)
                    rx_byte[(k - C / 2) / C - 1] = uart_tx;
                if (k == STOP_K && uart_tx !== 1'b1) begin
                    check("stop_bit", 32'(uart_tx), 32'd1);
                end
            end
            if (rx_ok) begin
                rx_data.push_back(rx_byte);
                rx_t.push_back(rx_t0);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        address = a; wb = v; w = 1'b1;
        cyc();
        w = 1'b0; address = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
        address = a; w = 1'b0; rd_req = 1'b1;
        sb_name.push_back(nm);
        sb_exp.push_back(e);
        cyc();
        rd_req = 1'b0; address = 16'h0000;
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 600 && rx_data.size() < n; i++) cyc();
    endtask

    task automatic check_frames(input logic [7:0] first, input int n);
        check("frame_count", 32'(rx_data.size()), 32'(n));
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            check("frame_byte", 32'(rx_data[i]), 32'(first + 8'(i)));
            if (i > 0) check("frame_gap", 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME));
        end
        rx_data.delete();
        rx_t.delete();
    endtask

    logic [7:0] pat;
    logic       tx_low_seen;

    initial begin
        for (int i = 0; i < 1024; i++) smem[i] = 8'h00;
        repeat (3) cyc();
        check("rst_data", 32'(data), 32'h00);
        check("rst_port_out", 32'(port_out), 32'h00);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_irq_udre", 32'(irq_udre), 32'd0);
        reset = 1'b0;
        cyc();

        // SRAM pass-through
        address = 16'h0100; wb = 8'hA5; w = 1'b1;
        #1;
        check("sram_we_hi", 32'(sram_we), 32'd1);
        check("sram_addr", 32'(sram_addr), 32'h0100);
        check("sram_wd", 32'(sram_wd), 32'hA5);
        cyc();
        w = 1'b0;
        #1;
        check("sram_we_pulse", 32'(sram_we), 32'd0);
        rd(16'h0100, 8'hA5, "sram_read");

        // PORTB write/read-back, no SRAM strobe in the window
        address = A_PORTB; wb = 8'h3C; w = 1'b1;
        #1;
        check("sram_we_io", 32'(sram_we), 32'd0);
        cyc();
        w = 1'b0;
        check("port_out", 32'(port_out), 32'h3C);
        rd(A_PORTB, 8'h3C, "portb_rb");
        rd(16'h0050, 8'h00, "unmapped_io");

        // PINB through two synchroniser flops
        pin_in = 8'h81;
        rd(A_PINB, 8'h00, "pinb_1clk");
        rd(A_PINB, 8'h00, "pinb_2clk");
        rd(A_PINB, 8'h81, "pinb_3clk");

        // UCR: only UDRIE is stored
        wr(A_UCR, 8'hFF);
        rd(A_UCR, 8'h20, "ucr_rb");
        check("irq_udre_en", 32'(irq_udre), 32'd1);
        rd(A_USR, 8'h20, "usr_idle");

        // Single frame 0x55, bit-exact line check
        pat = 8'h55;
        wr(A_UDR, pat);
        cyc();
        for (int j = 0; j < FRAME; j++) begin
            check("tx_line", 32'(uart_tx),
                  (j < C) ? 32'd0 : (j >= 9 * C) ? 32'd1 : 32'(pat[(j - C) / C]));
            cyc();
        end
        rd(A_USR, 8'h60, "usr_txc");
        rd(A_UDR, 8'h00, "udr_read");
        check_frames(8'h55, 1);
        wr(A_USR, 8'h40);
        rd(A_USR, 8'h20, "usr_txc_clr");

        // Six back-to-back pushes: five accepted, sixth overflows
        for (int i = 1; i <= 6; i++) wr(A_UDR, 8'(i));
        check("irq_udre_full", 32'(irq_udre), 32'd0);
        rd(A_USR, 8'h01, "usr_ovf");
        wait_rx(5);
        repeat (5) cyc();
        check_frames(8'h01, 5);
        rd(A_USR, 8'h61, "usr_ovf_txc");
        wr(A_USR, 8'h41);
        rd(A_USR, 8'h20, "usr_clr_both");
        check("irq_udre_empty", 32'(irq_udre), 32'd1);

        // Push lands on the STOP->START pop with the FIFO full
        wr(A_UDR, 8'h11);
        for (int i = 2; i <= 5; i++) wr(A_UDR, 8'(8'h10 + 8'(i)));
        check("irq_udre_full2", 32'(irq_udre), 32'd0);
        repeat (FRAME - 4) cyc();
        wr(A_UDR, 8'h16);
        check("irq_udre_collide", 32'(irq_udre), 32'd0);
        rd(A_USR, 8'h00, "usr_collide");
        wait_rx(6);
        repeat (5) cyc();
        check_frames(8'h11, 6);
        rd(A_USR, 8'h60, "usr_after_collide");
        check("irq_udre_drained", 32'(irq_udre), 32'd1);
        wr(A_USR, 8'h40);

        // Reset during DATA bit 3 aborts the frame and flushes the FIFO
        wr(A_UDR, 8'h3A);
        wr(A_UDR, 8'h3B);
        repeat (3 * C + 1 + C / 4) cyc();
        reset = 1'b1;
        cyc();
        check("rst_mid_tx", 32'(uart_tx), 32'd1);
        cyc();
        reset = 1'b0;
        check("rst_mid_irq", 32'(irq_udre), 32'd0);
        check("rst_mid_port", 32'(port_out), 32'h00);
        rd(A_USR, 8'h20, "usr_after_rst");
        tx_low_seen = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if (uart_tx !== 1'b1) tx_low_seen = 1'b1;
            cyc();
        end
        check("no_frame_after_rst", 32'(tx_low_seen), 32'd0);
        check("no_rx_after_rst", 32'(rx_data.size()), 32'd0);

        cyc();
        check("sb_drained", 32'(sb_exp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
